// File: rtl/layer_pkg.sv
// Shared definitions for the layer output packer: FSM encoding and the
// default fixed-point (Q-format) geometry.
package layer_pkg;

  typedef enum logic [1:0] {
    FSM_WAIT    = 2'd0,
    FSM_CONVERT = 2'd1,
    FSM_PUBLISH = 2'd2,
    FSM_RESTART = 2'd3
  } fsm_state_e;

  localparam logic [1:0] ST_WAIT    = FSM_WAIT;
  localparam logic [1:0] ST_CONVERT = FSM_CONVERT;
  localparam logic [1:0] ST_PUBLISH = FSM_PUBLISH;
  localparam logic [1:0] ST_RESTART = FSM_RESTART;

  localparam int Q_W    = 16;
  localparam int Q_FRAC = 12;
  localparam int Q_D    = 8;

endpackage

// File: rtl/fixed_point_requant.sv
// Round-half-up requantisation of a 2W-bit accumulator to a saturated W-bit
// element, with optional ReLU clamp.
module fixed_point_requant
  import layer_pkg::*;
#(
  parameter int W    = Q_W,
  parameter int FRAC = Q_FRAC,
  parameter int RELU = 0
) (
  input  logic signed [2*W-1:0] x,
  output logic signed [W-1:0]   y
);

  // One guard bit on the rounding add keeps 0x7FFF_FFFF + half from wrapping.
  localparam logic signed [2*W:0] ROUND_V = {{(2*W){1'b0}}, 1'b1} << (FRAC - 1);
  localparam logic signed [2*W:0] MAX_V   = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W:0] MIN_V   = {{(W+2){1'b1}}, {(W-1){1'b0}}};

  logic signed [2*W:0] sum_s;
  logic signed [2*W:0] shr_s;
  logic signed [W-1:0] sat_s;

  // Round, shift, saturate, then optionally clamp negatives.
  always_comb begin
    sum_s = {x[2*W-1], x} + ROUND_V;
    shr_s = sum_s >>> FRAC;
    if (shr_s > MAX_V) begin
      sat_s = {1'b0, {(W-1){1'b1}}};
    end else if (shr_s < MIN_V) begin
      sat_s = {1'b1, {(W-1){1'b0}}};
    end else begin
      sat_s = shr_s[W-1:0];
    end
    if ((RELU != 0) && sat_s[W-1]) begin
      y = '0;
    end else begin
      y = sat_s;
    end
  end

endmodule

// File: rtl/layer_output_packer.sv
// Collects D dot-product results, requantises them one per cycle into a
// packed W-bit vector, publishes it, then pulses a restart to the producers.
module layer_output_packer
  import layer_pkg::*;
#(
  parameter int W    = Q_W,
  parameter int D    = Q_D,
  parameter int FRAC = Q_FRAC,
  parameter int RELU = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [D*2*W-1:0] packed_dp_out,
  input  logic [D-1:0]            dp_out_v,
  output logic                    dp_rst,
  output logic signed [D*W-1:0]   packed_out,
  output logic                    out_v,
  input  logic                    out_ready
);

  localparam int IDX_W = (D > 1) ? $clog2(D) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(D - 1);

  logic [1:0]            state_r;
  logic [IDX_W-1:0]      idx_r;
  logic signed [2*W-1:0] cap_r  [D];
  logic signed [W-1:0]   slot_r [D];
  logic                  out_v_r;
  logic                  dp_rst_r;
  logic signed [2*W-1:0] elem_s;
  logic signed [W-1:0]   req_s;

  // Single shared requantiser, fed by the element selected by idx.
  always_comb begin
    elem_s = cap_r[idx_r];
  end

  fixed_point_requant #(
    .W    (W),
    .FRAC (FRAC),
    .RELU (RELU)
  ) u_requant (
    .x (elem_s),
    .y (req_s)
  );

  // Capture / convert / publish / restart sequencing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r  <= ST_WAIT;
      idx_r    <= '0;
      out_v_r  <= 1'b0;
      dp_rst_r <= 1'b1;
      for (int i = 0; i < D; i++) begin
        cap_r[i]  <= '0;
        slot_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_WAIT: begin
          dp_rst_r <= 1'b0;
          if (&dp_out_v) begin
            for (int i = 0; i < D; i++) begin
              cap_r[i] <= packed_dp_out[2*W*(D-1-i) +: 2*W];
            end
            idx_r   <= '0;
            state_r <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          slot_r[idx_r] <= req_s;
          if (idx_r == IDX_LAST) begin
            out_v_r <= 1'b1;
            state_r <= ST_PUBLISH;
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        ST_PUBLISH: begin
          if (out_ready) begin
            out_v_r  <= 1'b0;
            dp_rst_r <= 1'b1;
            state_r  <= ST_RESTART;
          end
        end
        ST_RESTART: begin
          dp_rst_r <= 1'b0;
          state_r  <= ST_WAIT;
        end
        default: begin
          out_v_r  <= 1'b0;
          dp_rst_r <= 1'b0;
          state_r  <= ST_WAIT;
        end
      endcase
    end
  end

  for (genvar g = 0; g < D; g++) begin : g_pack
    assign packed_out[W*(D-1-g) +: W] = slot_r[g];
  end

  assign out_v  = out_v_r;
  assign dp_rst = dp_rst_r;

endmodule

// File: tb/tb_layer_output_packer.sv
// Randomised bench for layer_output_packer (W=16, FRAC=12, D=8), run on a
// plain and a ReLU instance sharing the same stimulus.
module tb_layer_output_packer;

  localparam int W    = 16;
  localparam int D    = 8;
  localparam int FRAC = 12;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [D*2*W-1:0]     packed_dp_out;
  logic [D-1:0]         dp_out_v;
  logic                 out_ready;
  logic                 dp_rst_a, out_v_a, dp_rst_b, out_v_b;
  logic [D*W-1:0]       packed_out_a, packed_out_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] vec [D];

  always #5 clk = ~clk;

  layer_output_packer #(.W(W), .D(D), .FRAC(FRAC), .RELU(0)) dut (
    .clk           (clk),
    .rst           (rst),
    .packed_dp_out (packed_dp_out),
    .dp_out_v      (dp_out_v),
    .dp_rst        (dp_rst_a),
    .packed_out    (packed_out_a),
    .out_v         (out_v_a),
    .out_ready     (out_ready)
  );

  layer_output_packer #(.W(W), .D(D), .FRAC(FRAC), .RELU(1)) dut_relu (
    .clk           (clk),
    .rst           (rst),
    .packed_dp_out (packed_dp_out),
    .dp_out_v      (dp_out_v),
    .dp_rst        (dp_rst_b),
    .packed_out    (packed_out_b),
    .out_v         (out_v_b),
    .out_ready     (out_ready)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: floor((x + 2^(FRAC-1)) / 2^FRAC), saturate, optional ReLU.
  function automatic logic [15:0] ref_requant(input logic [31:0] x, input bit relu);
    longint n;
    longint q;
    n = longint'($signed(x)) + 64'sd2048;
    q = n / 64'sd4096;
    if (n < 64'sd0 && q * 64'sd4096 != n) q = q - 64'sd1;
    if (q > 64'sd32767) q = 64'sd32767;
    if (q < -64'sd32768) q = -64'sd32768;
    if (relu && q < 64'sd0) q = 64'sd0;
    return q[15:0];
  endfunction

  function automatic logic [127:0] ref_packed(input bit relu);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < D; i++) r[16*(D-1-i) +: 16] = ref_requant(vec[i], relu);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_inputs();
    for (int i = 0; i < D; i++) packed_dp_out[32*(D-1-i) +: 32] = vec[i];
  endtask

  task automatic scramble_inputs();
    for (int i = 0; i < D; i++) packed_dp_out[32*(D-1-i) +: 32] = $urandom;
  endtask

  task automatic random_vec();
    for (int i = 0; i < D; i++) begin
      logic [31:0] t;
      case ($urandom_range(0, 2))
        0: vec[i] = $urandom;
        1: begin
          t = $urandom;
          vec[i] = {{5{t[26]}}, t[26:0]};
        end
        default: begin
          t = (32'($urandom_range(0, 100)) << 12) + 32'd2048 - 32'($urandom_range(0, 1));
          vec[i] = ($urandom_range(0, 1) == 1) ? -t : t;
        end
      endcase
    end
  endtask

  // Capture one vector, check latency/result, hold, accept and restart.
  task automatic run_vector(input bit staggered, input int hold);
    logic [127:0] exp_a;
    logic [127:0] exp_b;
    int lat;
    exp_a = ref_packed(1'b0);
    exp_b = ref_packed(1'b1);
    if (staggered) begin
      for (int i = 0; i < D - 1; i++) begin
        dp_out_v[i] = 1'b1;
        scramble_inputs();
        tick();
        check("no_early_capture", {127'd0, out_v_a}, 128'd0);
      end
    end
    load_inputs();
    dp_out_v = '1;
    tick();
    scramble_inputs();
    dp_out_v = 8'($urandom) & 8'h7F;
    lat = 0;
    while (!out_v_a && lat < 20) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      lat++;
    end
    out_ready = 1'b0;
    check("latency", 128'(lat), 128'd8);
    check("out_v_relu", {127'd0, out_v_b}, 128'd1);
    check("data", packed_out_a, exp_a);
    check("data_relu", packed_out_b, exp_b);
    for (int c = 0; c < hold; c++) begin
      tick();
      check("hold_flags", {124'd0, out_v_a, out_v_b, dp_rst_a, dp_rst_b}, 128'hC);
      check("hold_data", packed_out_a, exp_a);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    dp_out_v = '0;
    check("accept", {124'd0, out_v_a, dp_rst_a, out_v_b, dp_rst_b}, 128'h5);
    tick();
    check("restart_end", {124'd0, out_v_a, dp_rst_a, out_v_b, dp_rst_b}, 128'h0);
    check("restart_hold", packed_out_a, exp_a);
    check("restart_hold_relu", packed_out_b, exp_b);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    dp_out_v = '0;
    packed_dp_out = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("reset_flags", {124'd0, out_v_a, dp_rst_a, out_v_b, dp_rst_b}, 128'h5);
    check("reset_data", packed_out_a, 128'd0);
    check("reset_data_relu", packed_out_b, 128'd0);
    rst = 1'b1;
    tick();
    check("reset_release", {126'd0, dp_rst_a, dp_rst_b}, 128'd0);

    for (int i = 0; i < D; i++) vec[i] = 32'h0100_0000;
    run_vector(1'b0, 3);

    vec[0] = 32'h7FFF_FFFF; vec[1] = 32'h8000_0000;
    vec[2] = 32'h0000_0800; vec[3] = 32'h0000_07FF;
    vec[4] = 32'hFFFF_F800; vec[5] = 32'hFFFF_F7FF;
    vec[6] = 32'h0000_1000; vec[7] = 32'hFFFF_F000;
    run_vector(1'b0, 20);

    random_vec();
    run_vector(1'b1, 2);

    // Reset while converting element 3.
    random_vec();
    load_inputs();
    dp_out_v = '1;
    tick();
    dp_out_v = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("midrst_flags", {124'd0, out_v_a, dp_rst_a, out_v_b, dp_rst_b}, 128'h5);
    check("midrst_data", packed_out_a, 128'd0);
    tick();
    check("midrst_flags2", {124'd0, out_v_a, dp_rst_a, out_v_b, dp_rst_b}, 128'h5);
    check("midrst_data_relu", packed_out_b, 128'd0);
    rst = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check("midrst_no_pulse", {124'd0, out_v_a, dp_rst_a, out_v_b, dp_rst_b}, 128'h0);
    end
    random_vec();
    run_vector(1'b0, 1);

    for (int n = 0; n < 15; n++) begin
      random_vec();
      run_vector(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_output_packer.md
LAYER_OUTPUT_PACKER -- requirements
Module: layer_output_packer

Interface
REQ-001 SHALL have parameter W, default 16, meaning the width of one packed output element.
REQ-002 SHALL have parameter D, default 8, meaning the number of dot products collected.
REQ-003 SHALL have parameter FRAC, default 12, meaning the fraction bits of the W-bit fixed-point format.
REQ-004 SHALL have parameter RELU, default 0; when 1, negative results are clamped to 0.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port packed_dp_out, input, D*2W bits, signed: element i at [2W*(D-i-1) +: 2W].
REQ-008 SHALL have port dp_out_v, input, D bits: bit i is the level valid for element i, held until the dot products restart.
REQ-009 SHALL have port dp_rst, output, 1 bit: active-high restart driven to all D dot products.
REQ-010 SHALL have port packed_out, output, D*W bits, signed: element i at [W*(D-i-1) +: W].
REQ-011 SHALL have port out_v, output, 1 bit: packed_out is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts packed_out.

Function
REQ-013 SHALL implement FSM states WAIT, CONVERT, PUBLISH and RESTART.
REQ-014 In WAIT, on the edge sampling &dp_out_v==1, SHALL capture all D inputs, set idx=0 and go to CONVERT; partial valids SHALL wait indefinitely.
REQ-015 In CONVERT, SHALL requantise one element per cycle (element idx) into packed_out slot idx, for idx 0..D-1; on idx==D-1 it SHALL go to PUBLISH with out_v<=1.
REQ-016 Latency: out_v SHALL rise exactly D edges after the capture edge.
REQ-017 Requantise: y = (x + 2^(FRAC-1)) >>> FRAC, computed with no overflow in the rounding add.
REQ-018 Requantise: y SHALL saturate to [-2^(W-1), 2^(W-1)-1].
REQ-019 Requantise: if RELU==1, a negative y SHALL become 0.
REQ-020 Input changes after capture, including dp_out_v bits dropping, SHALL be ignored until the next WAIT.
REQ-021 In PUBLISH, out_v and packed_out SHALL stay stable while out_ready==0.
REQ-022 In PUBLISH, on an edge with out_ready==1, SHALL set out_v<=0, dp_rst<=1 and go to RESTART.
REQ-023 out_ready outside PUBLISH SHALL be ignored.
REQ-024 RESTART SHALL last exactly one cycle, then set dp_rst<=0 and go to WAIT; packed_out SHALL hold its last value.
REQ-025 dp_rst SHALL be high for exactly one cycle per accepted vector, and never in WAIT, CONVERT or PUBLISH.

Reset
REQ-026 While rst==0 at an edge: state=WAIT, idx=0, out_v=0, packed_out=0, capture registers=0, dp_rst=1, so the dot products are held in reset.
REQ-027 At the first edge with rst==1: dp_rst<=0 and the FSM starts in WAIT.
REQ-028 Reset asserted in any state, mid-CONVERT or mid-PUBLISH included, SHALL abort the operation with no output pulse.

Structure
REQ-029 The package layer_pkg SHALL hold the FSM state enum and the Q-format constants.
REQ-030 Requantisation SHALL live in one sub-module, fixed_point_requant (parameters W, FRAC, RELU; 2W-bit input to W-bit output), instantiated once and muxed by idx.

Verification (W=16, FRAC=12, D=8)
REQ-031 All 8 inputs 0x01000000 with all valids set on one edge -> out_v high 8 edges later; every element 0x1000.
REQ-032 Inputs 0x7FFFFFFF, 0x80000000 -> 0x7FFF, 0x8000; with RELU=1 the second -> 0x0000.
REQ-033 Inputs 0x00000800, 0x000007FF, 0xFFFFF800, 0xFFFFF7FF -> 0x0001, 0x0000, 0x0000, 0xFFFF.
REQ-034 Valid bits set one per cycle over 8 cycles -> no capture before the last bit; out_v rises 8 edges after it.
REQ-035 out_ready low for 20 cycles, then high for 1 -> out_v and packed_out stable throughout; out_v low next cycle; dp_rst high for exactly 1 cycle; FSM back in WAIT.
REQ-036 rst low during CONVERT idx=3 -> out_v=0, packed_out=0, dp_rst=1 while low; a fresh full-valid vector after release -> correct output.
